// File: rtl/pc_word_deserializer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_word_deserializer_pkg : code constants and lane widths for PC->FPGA words
// Revision 1.0
// ---------------------------------------------------------------------------
package pc_word_deserializer_pkg;

  localparam int NPC_CODE   = 8;
  localparam int NPC_DATA   = 24;
  localparam int N_TIME     = 48;
  localparam int N_SF_FILTS = 10;
  localparam int N_SF_STATE = 27;
  localparam int N_SF       = N_SF_FILTS + N_SF_STATE;
  localparam int DROP_W     = 16;

  localparam logic [NPC_CODE-1:0] TS_CODE = 8'd13;
  localparam logic [NPC_CODE-1:0] SF_CODE = 8'd14;
  localparam logic [NPC_CODE-1:0] RW_CODE = 8'd15;

  typedef enum logic [0:0] {
    LANE_FILL = 1'b0,
    LANE_FULL = 1'b1
  } lane_state_t;

endpackage
`default_nettype wire

// File: rtl/pc_word_deserializer_lane.sv
`default_nettype none
// ---------------------------------------------------------------------------
// deserializer_lane : gathers NIN-bit chunks (LS chunk first) into NOUT bits
// Revision 1.0
// ---------------------------------------------------------------------------
module deserializer_lane
  import pc_word_deserializer_pkg::*;
#(
  parameter int NIN  = 24,
  parameter int NOUT = 48
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_v,
  input  logic [NIN-1:0]  in_d,
  output logic            in_a,
  output logic [NOUT-1:0] out_d,
  output logic            out_v,
  input  logic            out_a
);

  localparam int W     = (NOUT + NIN - 1) / NIN;
  localparam int IDX_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(W - 1);

  lane_state_t      state, state_next;
  logic [IDX_W-1:0] idx;
  logic [NOUT-1:0]  acc;
  logic             load;
  logic             last;

  assign load  = in_v && in_a;
  assign last  = (idx == LAST_IDX);
  assign out_d = acc;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= LANE_FILL;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_a       = 1'b0;
    out_v      = 1'b0;
    case (state)
      LANE_FILL: begin
        in_a = 1'b1;
        if (load && last) state_next = LANE_FULL;
      end
      LANE_FULL: begin
        out_v = 1'b1;
        if (out_a) state_next = LANE_FILL;
      end
      default: state_next = LANE_FILL;
    endcase
  end

  // Only bits below NOUT are stored; the excess of the final chunk is dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx <= '0;
      acc <= '0;
    end else if (load) begin
      idx <= last ? '0 : idx + 1'b1;
      for (int b = 0; b < NOUT; b++) begin
        if (idx == IDX_W'(b / NIN)) acc[b] <= in_d[b % NIN];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_word_deserializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pc_word_deserializer : routes coded PC words to TS/SF/RW assembly lanes
// Revision 1.0
// ---------------------------------------------------------------------------
module pc_word_deserializer
  import pc_word_deserializer_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [NPC_CODE-1:0] PC_in_code,
  input  logic [NPC_DATA-1:0] PC_in_payload,
  input  logic                PC_in_v,
  output logic                PC_in_a,
  output logic [N_TIME-1:0]   TS_out_d,
  output logic                TS_out_v,
  input  logic                TS_out_a,
  output logic [N_SF-1:0]     SF_out_d,
  output logic                SF_out_v,
  input  logic                SF_out_a,
  output logic [NPC_DATA-1:0] RW_out_d,
  output logic                RW_out_v,
  input  logic                RW_out_a,
  output logic [DROP_W-1:0]   drop_count
);

  logic is_ts, is_sf, is_rw, is_other;
  logic ts_in_a, sf_in_a, rw_in_a;

  assign is_ts    = (PC_in_code == TS_CODE);
  assign is_sf    = (PC_in_code == SF_CODE);
  assign is_rw    = (PC_in_code == RW_CODE);
  assign is_other = !(is_ts || is_sf || is_rw);

  deserializer_lane #(.NIN(NPC_DATA), .NOUT(N_TIME)) u_ts_lane (
    .clk(clk), .reset(reset),
    .in_v(PC_in_v && is_ts), .in_d(PC_in_payload), .in_a(ts_in_a),
    .out_d(TS_out_d), .out_v(TS_out_v), .out_a(TS_out_a)
  );

  deserializer_lane #(.NIN(NPC_DATA), .NOUT(N_SF)) u_sf_lane (
    .clk(clk), .reset(reset),
    .in_v(PC_in_v && is_sf), .in_d(PC_in_payload), .in_a(sf_in_a),
    .out_d(SF_out_d), .out_v(SF_out_v), .out_a(SF_out_a)
  );

  deserializer_lane #(.NIN(NPC_DATA), .NOUT(NPC_DATA)) u_rw_lane (
    .clk(clk), .reset(reset),
    .in_v(PC_in_v && is_rw), .in_d(PC_in_payload), .in_a(rw_in_a),
    .out_d(RW_out_d), .out_v(RW_out_v), .out_a(RW_out_a)
  );

  // Unknown codes are always swallowed so they can never block the link.
  always_comb begin
    PC_in_a = 1'b0;
    if (reset) begin
      if (is_ts)      PC_in_a = ts_in_a;
      else if (is_sf) PC_in_a = sf_in_a;
      else if (is_rw) PC_in_a = rw_in_a;
      else            PC_in_a = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      drop_count <= '0;
    end else if (PC_in_v && is_other && (drop_count != '1)) begin
      drop_count <= drop_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pc_word_deserializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pc_word_deserializer : directed scenarios plus randomized run vs model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_pc_word_deserializer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  PC_in_code = 8'd0;
  logic [23:0] PC_in_payload = 24'd0;
  logic        PC_in_v = 1'b0;
  logic        PC_in_a;
  logic [47:0] TS_out_d;
  logic        TS_out_v;
  logic        TS_out_a = 1'b0;
  logic [36:0] SF_out_d;
  logic        SF_out_v;
  logic        SF_out_a = 1'b0;
  logic [23:0] RW_out_d;
  logic        RW_out_v;
  logic        RW_out_a = 1'b0;
  logic [15:0] drop_count;

  int total = 0;
  int bad = 0;

  pc_word_deserializer dut (
    .clk(clk), .reset(reset),
    .PC_in_code(PC_in_code), .PC_in_payload(PC_in_payload),
    .PC_in_v(PC_in_v), .PC_in_a(PC_in_a),
    .TS_out_d(TS_out_d), .TS_out_v(TS_out_v), .TS_out_a(TS_out_a),
    .SF_out_d(SF_out_d), .SF_out_v(SF_out_v), .SF_out_a(SF_out_a),
    .RW_out_d(RW_out_d), .RW_out_v(RW_out_v), .RW_out_a(RW_out_a),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Reference model: a lane is a list of collected chunks plus a pending message.
  int          m_words [3] = '{2, 2, 1};
  int          m_width [3] = '{48, 37, 24};
  logic [71:0] m_acc   [3];
  int          m_cnt   [3];
  bit          m_full  [3];
  logic [47:0] m_msg   [3];
  int          m_drop;

  function automatic int lane_of(input logic [7:0] code);
    if (code == 8'd13) return 0;
    if (code == 8'd14) return 1;
    if (code == 8'd15) return 2;
    return -1;
  endfunction

  function automatic bit exp_in_a();
    int l;
    if (!reset) return 1'b0;
    l = lane_of(PC_in_code);
    return (l < 0) ? 1'b1 : !m_full[l];
  endfunction

  function automatic void model_update();
    bit oa [3];
    bit acc_ok;
    int l;
    logic [71:0] msg;
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        m_acc[i] = '0; m_cnt[i] = 0; m_full[i] = 0; m_msg[i] = '0;
      end
      m_drop = 0;
      return;
    end
    oa[0] = TS_out_a; oa[1] = SF_out_a; oa[2] = RW_out_a;
    l = lane_of(PC_in_code);
    acc_ok = PC_in_v && ((l < 0) || !m_full[l]);
    for (int i = 0; i < 3; i++) if (m_full[i] && oa[i]) m_full[i] = 0;
    if (acc_ok) begin
      if (l < 0) begin
        if (m_drop < 65535) m_drop++;
      end else begin
        m_acc[l] = m_acc[l] + (72'(PC_in_payload) << (24 * m_cnt[l]));
        m_cnt[l]++;
        if (m_cnt[l] == m_words[l]) begin
          msg = m_acc[l] & ((72'd1 << m_width[l]) - 72'd1);
          m_msg[l] = msg[47:0];
          m_full[l] = 1;
          m_acc[l] = '0;
          m_cnt[l] = 0;
        end
      end
    end
  endfunction

  task automatic tick();
    @(negedge clk);
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] code, input logic [23:0] pay, input logic v);
    PC_in_code = code; PC_in_payload = pay; PC_in_v = v;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; PC_in_v = 1'b0;
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    put(8'd13, 24'h5A5A5A, 1'b1);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (PC_in_a !== 1'b0) begin bad++; $display("FAIL reset_in_a got=%b want=0", PC_in_a); end
      total++;
      if ({TS_out_v, SF_out_v, RW_out_v} !== 3'b000) begin
        bad++; $display("FAIL reset_out_v got=%b want=000", {TS_out_v, SF_out_v, RW_out_v});
      end
      total++;
      if (drop_count !== 16'd0) begin bad++; $display("FAIL reset_drop got=%0d want=0", drop_count); end
      tick();
    end
    PC_in_v = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_ts();
    do_reset();
    TS_out_a = 1'b1;
    put(8'd13, 24'h123456, 1'b1);
    total++;
    if (PC_in_a !== 1'b1) begin bad++; $display("FAIL ts_in_a0 got=%b want=1", PC_in_a); end
    tick();
    total++;
    if (TS_out_v !== 1'b0) begin bad++; $display("FAIL ts_early_v got=%b want=0", TS_out_v); end
    put(8'd13, 24'hABCDEF, 1'b1);
    total++;
    if (PC_in_a !== 1'b1) begin bad++; $display("FAIL ts_in_a1 got=%b want=1", PC_in_a); end
    tick();
    put(8'd13, 24'h0, 1'b0);
    total++;
    if (TS_out_v !== 1'b1 || TS_out_d !== 48'hABCDEF123456) begin
      bad++; $display("FAIL ts_out got v=%b d=%h want v=1 d=abcdef123456", TS_out_v, TS_out_d);
    end
    total++;
    if (PC_in_a !== 1'b0) begin bad++; $display("FAIL ts_full_in_a got=%b want=0", PC_in_a); end
    tick();
    total++;
    if (TS_out_v !== 1'b0 || PC_in_a !== 1'b1) begin
      bad++; $display("FAIL ts_drain got v=%b a=%b want v=0 a=1", TS_out_v, PC_in_a);
    end
    TS_out_a = 1'b0;
  endtask

  task automatic test_interleave();
    logic [47:0] sf_w;
    do_reset();
    put(8'd14, 24'hC0FFEE, 1'b1); tick();
    put(8'd13, 24'h111111, 1'b1); tick();
    put(8'd14, 24'hFEDCBA, 1'b1); tick();
    sf_w = {24'hFEDCBA, 24'hC0FFEE};
    total++;
    if (SF_out_v !== 1'b1 || SF_out_d !== sf_w[36:0] || TS_out_v !== 1'b0) begin
      bad++; $display("FAIL il_sf got v=%b d=%h tsv=%b want v=1 d=%h tsv=0",
                      SF_out_v, SF_out_d, TS_out_v, sf_w[36:0]);
    end
    put(8'd13, 24'h222222, 1'b1); tick();
    PC_in_v = 1'b0;
    total++;
    if (TS_out_v !== 1'b1 || TS_out_d !== 48'h222222111111) begin
      bad++; $display("FAIL il_ts got v=%b d=%h want v=1 d=222222111111", TS_out_v, TS_out_d);
    end
    total++;
    if (SF_out_d !== sf_w[36:0]) begin
      bad++; $display("FAIL il_sf_hold got=%h want=%h", SF_out_d, sf_w[36:0]);
    end
    TS_out_a = 1'b1; SF_out_a = 1'b1; tick();
    TS_out_a = 1'b0; SF_out_a = 1'b0;
  endtask

  task automatic test_rw_stall();
    do_reset();
    RW_out_a = 1'b0;
    put(8'd15, 24'h111111, 1'b1); tick();
    put(8'd15, 24'h222222, 1'b1);
    total++;
    if (PC_in_a !== 1'b0) begin bad++; $display("FAIL rw_stall got=%b want=0", PC_in_a); end
    tick();
    put(8'd13, 24'h333333, 1'b1);
    total++;
    if (PC_in_a !== 1'b1) begin bad++; $display("FAIL rw_other_flow got=%b want=1", PC_in_a); end
    tick();
    total++;
    if (RW_out_v !== 1'b1 || RW_out_d !== 24'h111111) begin
      bad++; $display("FAIL rw_hold got v=%b d=%h want v=1 d=111111", RW_out_v, RW_out_d);
    end
    put(8'd15, 24'h222222, 1'b1);
    RW_out_a = 1'b1;
    #1;
    tick();
    total++;
    if (PC_in_a !== 1'b1 || RW_out_v !== 1'b0) begin
      bad++; $display("FAIL rw_refill got a=%b v=%b want a=1 v=0", PC_in_a, RW_out_v);
    end
    tick();
    PC_in_v = 1'b0;
    total++;
    if (RW_out_v !== 1'b1 || RW_out_d !== 24'h222222) begin
      bad++; $display("FAIL rw_second got v=%b d=%h want v=1 d=222222", RW_out_v, RW_out_d);
    end
    tick();
    RW_out_a = 1'b0;
  endtask

  task automatic test_drop();
    do_reset();
    put(8'h22, 24'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (PC_in_a !== 1'b1) begin bad++; $display("FAIL drop_in_a got=%b want=1", PC_in_a); end
      tick();
    end
    PC_in_v = 1'b0;
    total++;
    if (drop_count !== 16'd3) begin bad++; $display("FAIL drop_three got=%0d want=3", drop_count); end
    PC_in_v = 1'b1;
    for (int i = 0; i < 65532; i++) tick();
    total++;
    if (drop_count !== 16'hFFFF) begin bad++; $display("FAIL drop_max got=%h want=ffff", drop_count); end
    tick(); tick();
    PC_in_v = 1'b0;
    total++;
    if (drop_count !== 16'hFFFF) begin bad++; $display("FAIL drop_sat got=%h want=ffff", drop_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    put(8'd13, 24'h777777, 1'b1); tick();
    reset = 1'b0; tick();
    reset = 1'b1;
    put(8'd13, 24'h000001, 1'b1); tick();
    total++;
    if (TS_out_v !== 1'b0) begin bad++; $display("FAIL rmid_stale got v=%b want=0", TS_out_v); end
    put(8'd13, 24'h000002, 1'b1); tick();
    PC_in_v = 1'b0;
    total++;
    if (TS_out_v !== 1'b1 || TS_out_d !== 48'h000002000001) begin
      bad++; $display("FAIL rmid_ts got v=%b d=%h want v=1 d=000002000001", TS_out_v, TS_out_d);
    end
    TS_out_a = 1'b1; tick(); TS_out_a = 1'b0;
  endtask

  task automatic test_random();
    int sel;
    logic [7:0] code;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      sel = int'($urandom_range(0, 4));
      code = (sel == 0) ? 8'd13 : (sel == 1) ? 8'd14 : (sel == 2) ? 8'd15 :
             8'($urandom_range(16, 255));
      TS_out_a = ($urandom_range(0, 1) == 1);
      SF_out_a = ($urandom_range(0, 1) == 1);
      RW_out_a = ($urandom_range(0, 1) == 1);
      put(code, 24'($urandom), ($urandom_range(0, 3) != 0));
      total++;
      if (PC_in_a !== exp_in_a()) begin
        bad++; $display("FAIL rnd_in_a n=%0d got=%b want=%b", n, PC_in_a, exp_in_a());
      end
      total++;
      if (TS_out_v !== m_full[0] || (m_full[0] && TS_out_d !== m_msg[0])) begin
        bad++; $display("FAIL rnd_ts n=%0d got v=%b d=%h want v=%b d=%h", n, TS_out_v, TS_out_d, m_full[0], m_msg[0]);
      end
      total++;
      if (SF_out_v !== m_full[1] || (m_full[1] && SF_out_d !== m_msg[1][36:0])) begin
        bad++; $display("FAIL rnd_sf n=%0d got v=%b d=%h want v=%b d=%h", n, SF_out_v, SF_out_d, m_full[1], m_msg[1][36:0]);
      end
      total++;
      if (RW_out_v !== m_full[2] || (m_full[2] && RW_out_d !== m_msg[2][23:0])) begin
        bad++; $display("FAIL rnd_rw n=%0d got v=%b d=%h want v=%b d=%h", n, RW_out_v, RW_out_d, m_full[2], m_msg[2][23:0]);
      end
      total++;
      if (int'(drop_count) != m_drop) begin
        bad++; $display("FAIL rnd_drop n=%0d got=%0d want=%0d", n, drop_count, m_drop);
      end
      tick();
    end
    PC_in_v = 1'b0;
    TS_out_a = 1'b0; SF_out_a = 1'b0; RW_out_a = 1'b0;
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_ts();
    test_interleave();
    test_rw_stall();
    test_drop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
